multi_cycle_ctrl: RTL

Parametrised multi-cycle control unit for the XLEN-bit CPU. It replaces the single-cycle decode path with a FETCH/DECODE/EXEC/MEM/WB state machine. It owns the program counter, the instruction register and a hardware return-address stack (RAS) for CALL/RET. Instruction and data memories are reached through ready/request handshakes, so wait-state memories are tolerated; the datapath (register file, ALU, sign-extend, muxes) is driven by the strobes produced here.

---
 rtl/multi_cycle_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit.
// Owns pc, instruction register, return-address stack and retire counter.
module multi_cycle_ctrl #(
  parameter int XLEN = 19,
  parameter int RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic            alu_zero,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            reg_we,
  output logic            alu_src,
  output logic            result_src,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [31:0]     instret
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_I    = 5'b00001;
  localparam logic [4:0] OP_S    = 5'b00010;
  localparam logic [4:0] OP_BEQ  = 5'b00011;
  localparam logic [4:0] OP_BNE  = 5'b00100;
  localparam logic [4:0] OP_JMP  = 5'b00101;
  localparam logic [4:0] OP_CALL = 5'b00110;
  localparam logic [4:0] OP_RET  = 5'b00111;
  localparam logic [4:0] OP_LD   = 5'b01000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic [2:0]      state;
  logic            run;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_dec;
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [4:0]      op;
  logic            is_r, is_i, is_s, is_ld;
  logic            is_beq, is_bne, is_jmp;
  logic            is_call, is_ret, is_halt;
  logic            legal;
  logic            ras_full, ras_empty;
  logic            push, retire;
  logic [XLEN-1:0] pc_inc, br_tgt, jmp_tgt, ras_top;

  assign op      = instr[XLEN-1:XLEN-5];
  assign is_r    = (op == OP_R);
  assign is_i    = (op == OP_I);
  assign is_s    = (op == OP_S);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_jmp  = (op == OP_JMP);
  assign is_call = (op == OP_CALL);
  assign is_ret  = (op == OP_RET);
  assign is_ld   = (op == OP_LD);
  assign is_halt = (op == OP_HALT);
  assign legal   = is_r | is_i | is_s | is_beq | is_bne | is_jmp
                 | is_call | is_ret | is_ld | is_halt;

  assign pc_inc  = pc + XLEN'(1);
  assign br_tgt  = pc + {{(XLEN-8){instr[7]}}, instr[7:0]};
  assign jmp_tgt = {5'b0, instr[XLEN-6:0]};

  assign ras_full  = (cnt == CW'(RAS_DEPTH));
  assign ras_empty = (cnt == '0);
  assign cnt_dec   = cnt - CW'(1);
  assign ras_top   = ras[cnt_dec[AW-1:0]];
  assign push      = (state == S_EXEC) & is_call & ~ras_full;

  // run gates imem_req so it only rises on the first edge after reset
  assign imem_req   = run & (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (state == S_MEM) & is_s;
  assign reg_we     = (state == S_WB);
  assign result_src = (state == S_WB) & is_ld;
  assign alu_src    = is_i | is_s | is_ld;
  assign halted     = (state == S_HALT);
  assign fault      = (state == S_FAULT);

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC: retire = is_beq | is_bne | is_jmp
                     | (is_call & ~ras_full)
                     | (is_ret & ~ras_empty);
      S_MEM:  retire = is_s & dmem_ready;
      S_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) ras[cnt[AW-1:0]] <= pc_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_FETCH;
      run        <= 1'b0;
      pc         <= RESET_PC;
      instr      <= '0;
      cnt        <= '0;
      fault_code <= 2'b00;
      instret    <= '0;
    end else begin
      run <= 1'b1;
      if (retire) instret <= instret + 32'd1;
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            instr <= imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            fault_code <= 2'b01;
            state      <= S_FAULT;
          end else if (is_halt) begin
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            is_r, is_i:  state <= S_WB;
            is_s, is_ld: state <= S_MEM;
            is_beq: begin
              pc    <= alu_zero ? br_tgt : pc_inc;
              state <= S_FETCH;
            end
            is_bne: begin
              pc    <= alu_zero ? pc_inc : br_tgt;
              state <= S_FETCH;
            end
            is_jmp: begin
              pc    <= jmp_tgt;
              state <= S_FETCH;
            end
            is_call: begin
              if (ras_full) begin
                fault_code <= 2'b10;
                state      <= S_FAULT;
              end else begin
                cnt   <= cnt + CW'(1);
                pc    <= jmp_tgt;
                state <= S_FETCH;
              end
            end
            is_ret: begin
              if (ras_empty) begin
                fault_code <= 2'b11;
                state      <= S_FAULT;
              end else begin
                cnt   <= cnt_dec;
                pc    <= ras_top;
                state <= S_FETCH;
              end
            end
            default: begin
              fault_code <= 2'b01;
              state      <= S_FAULT;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_s) begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        default: state <= state;
      endcase
    end
  end

endmodule
